// File: rtl/test_control.sv
// test_control: skew-in / stream / skew-out / drain / load sequencer for an NxM systolic array.
// Build with TEST_CONTROL_RESTART_EN defined to loop LOAD back to SKEW_IN for the next tile.
module test_control #(
  parameter int N = 3,
  parameter int M = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         finished,
  output logic [N-1:0] A_start_en,
  output logic [M-1:0] B_start_en,
  output logic         load
);

  // state    | meaning
  // IDLE     | first edge after reset release, enables still zero
  // SKEW_IN  | enables fill one row/column per edge
  // STREAM   | enables all high until the finished flag is seen
  // SKEW_OUT | enables empty one row/column per edge
  // DRAIN    | array flush plus MAC register, N+M-1 cycles
  // LOAD     | one-cycle load pulse
  // DONE     | parked with outputs low until reset

  localparam int CW = $clog2(N + M) + 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(N + M - 2);

  typedef enum logic [2:0] {
    IDLE, SKEW_IN, STREAM, SKEW_OUT, DRAIN, LOAD, DONE
  } state_t;

  state_t        state_q;
  logic [N-1:0]  a_en_q;
  logic [M-1:0]  b_en_q;
  logic          load_q;
  logic [CW-1:0] cnt_q;
  logic          fin_q;

  logic [N-1:0]  a_fill_d;
  logic [N-1:0]  a_empty_d;
  logic [M-1:0]  b_fill_d;
  logic [M-1:0]  b_empty_d;

  // A saturated vector shifts into itself unchanged, so the shorter side simply holds.
  assign a_fill_d  = {a_en_q[N-2:0], 1'b1};
  assign b_fill_d  = {b_en_q[M-2:0], 1'b1};
  assign a_empty_d = {a_en_q[N-2:0], 1'b0};
  assign b_empty_d = {b_en_q[M-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_en_q  <= '0;
      b_en_q  <= '0;
      load_q  <= 1'b0;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      load_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          state_q <= SKEW_IN;
        end
        SKEW_IN: begin
          a_en_q <= a_fill_d;
          b_en_q <= b_fill_d;
          if (finished) fin_q <= 1'b1;
          if (&a_fill_d && &b_fill_d) state_q <= STREAM;
        end
        STREAM: begin
          if (finished) fin_q <= 1'b1;
          if (fin_q) state_q <= SKEW_OUT;
        end
        SKEW_OUT: begin
          a_en_q <= a_empty_d;
          b_en_q <= b_empty_d;
          if (a_empty_d == '0 && b_empty_d == '0) begin
            state_q <= DRAIN;
            cnt_q   <= DRAIN_LAST;
          end
        end
        DRAIN: begin
          if (cnt_q == '0) begin
            state_q <= LOAD;
            load_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        LOAD: begin
          fin_q  <= 1'b0;
          a_en_q <= '0;
          b_en_q <= '0;
`ifdef TEST_CONTROL_RESTART_EN
          state_q <= SKEW_IN;
`else
          state_q <= DONE;
`endif
        end
        DONE: begin
          a_en_q <= '0;
          b_en_q <= '0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign A_start_en = a_en_q;
  assign B_start_en = b_en_q;
  assign load       = load_q;

endmodule

// File: tb/tb_test_control.sv
// Bench for test_control: a 3x3 and a 2x3 instance share clk/rst/finished and are checked
// against a timeline model derived from phase lengths (fill, stream, empty, drain, load).
module tb_test_control;

`ifdef TEST_CONTROL_RESTART_EN
  localparam bit RESTART = 1'b1;
`else
  localparam bit RESTART = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       finished = 1'b0;
  logic [2:0] a33, b33, b23;
  logic [1:0] a23;
  logic       ld33, ld23;

  always #5 clk = ~clk;

  test_control #(.N(3), .M(3)) u_dut33 (
    .clk(clk), .rst(rst), .finished(finished),
    .A_start_en(a33), .B_start_en(b33), .load(ld33)
  );

  test_control #(.N(2), .M(3)) u_dut23 (
    .clk(clk), .rst(rst), .finished(finished),
    .A_start_en(a23), .B_start_en(b23), .load(ld23)
  );

  int total = 0;
  int bad = 0;
  int k = 0;
  int base [2];
  int fset [2];
  int nn [2] = '{3, 2};
  int mm [2] = '{3, 3};
  logic [15:0] exp_a [2];
  logic [15:0] exp_b [2];
  logic        exp_l [2];

  function automatic int mx(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  function automatic int mn(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  function automatic int ones(input int j);
    return (j <= 0) ? 0 : ((1 << j) - 1);
  endfunction

  // Edge (relative to the run start) at which load is high, given the flag-set edge f.
  function automatic int load_edge(input int n, input int m, input int f);
    int s;
    s = mx(n, m);
    return mx(f, s + 1) + 1 + s + n + m - 1;
  endfunction

  function automatic void expect_at(input int n, input int m, input int r, input int f,
                                    output logic [15:0] ea, output logic [15:0] eb,
                                    output logic el);
    int s, o, d;
    s  = mx(n, m);
    ea = '0;
    eb = '0;
    el = 1'b0;
    if (f == 0) begin
      ea = 16'(ones(mn(r - 1, n)));
      eb = 16'(ones(mn(r - 1, m)));
    end else begin
      o = mx(f, s + 1) + 1;
      d = o + s;
      if (r < o) begin
        ea = 16'(ones(mn(r - 1, n)));
        eb = 16'(ones(mn(r - 1, m)));
      end else if (r < d) begin
        ea = 16'(ones(n) & ~ones(r - o));
        eb = 16'(ones(m) & ~ones(r - o));
      end else if (r == load_edge(n, m, f)) begin
        el = 1'b1;
      end
    end
  endfunction

  function automatic void model_edge(input bit fin);
    int r;
    k++;
    for (int i = 0; i < 2; i++) begin
      r = k - base[i];
      if (RESTART && fset[i] != 0 && r == load_edge(nn[i], mm[i], fset[i]) + 1) begin
        base[i] = k - 1;
        fset[i] = 0;
        r = 1;
      end
      if (fset[i] == 0 && r >= 2 && fin) fset[i] = r;
      expect_at(nn[i], mm[i], r, fset[i], exp_a[i], exp_b[i], exp_l[i]);
    end
  endfunction

  function automatic void model_reset();
    k = 0;
    for (int i = 0; i < 2; i++) begin
      base[i] = 0;
      fset[i] = 0;
    end
  endfunction

  task automatic tick(input bit fin);
    finished = fin;
    @(posedge clk);
    model_edge(fin);
    @(negedge clk);
  endtask

  task automatic reset_cycle();
    rst = 1'b0;
    finished = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({a33, b33, ld33, a23, b23, ld23} !== 13'd0) begin
      bad++;
      $display("FAIL reset_hold got %b exp 0", {a33, b33, ld33, a23, b23, ld23});
    end
    rst = 1'b1;
    model_reset();
    for (int c = 1; c <= 5; c++) begin
      tick(1'b0);
      total++;
      if ({13'd0, a33, 13'd0, b33, ld33} !== {exp_a[0], exp_b[0], exp_l[0]}) begin
        bad++;
        $display("FAIL reset_seq33 E%0d got a=%b b=%b ld=%b exp a=%b b=%b ld=%b",
                 c, a33, b33, ld33, exp_a[0][2:0], exp_b[0][2:0], exp_l[0]);
      end
      total++;
      if ({14'd0, a23, 13'd0, b23, ld23} !== {exp_a[1], exp_b[1], exp_l[1]}) begin
        bad++;
        $display("FAIL reset_seq23 E%0d got a=%b b=%b ld=%b exp a=%b b=%b ld=%b",
                 c, a23, b23, ld23, exp_a[1][1:0], exp_b[1][2:0], exp_l[1]);
      end
    end
  endtask

  task automatic test_basic();
    reset_cycle();
    for (int c = 1; c <= 20; c++) begin
      tick(c == 6);
      total++;
      if ({13'd0, a33, 13'd0, b33, ld33} !== {exp_a[0], exp_b[0], exp_l[0]}) begin
        bad++;
        $display("FAIL basic33 E%0d got a=%b b=%b ld=%b exp a=%b b=%b ld=%b",
                 c, a33, b33, ld33, exp_a[0][2:0], exp_b[0][2:0], exp_l[0]);
      end
      total++;
      if ({14'd0, a23, 13'd0, b23, ld23} !== {exp_a[1], exp_b[1], exp_l[1]}) begin
        bad++;
        $display("FAIL basic23 E%0d got a=%b b=%b ld=%b exp a=%b b=%b ld=%b",
                 c, a23, b23, ld23, exp_a[1][1:0], exp_b[1][2:0], exp_l[1]);
      end
      if (c == 8) begin
        total++;
        if (a33 !== 3'b110) begin
          bad++;
          $display("FAIL basic_E8_en got %b exp 110", a33);
        end
      end
      if (c == 15) begin
        total++;
        if (ld33 !== 1'b1) begin
          bad++;
          $display("FAIL basic_E15_load got %b exp 1", ld33);
        end
      end
    end
  endtask

  task automatic test_early_finish();
    reset_cycle();
    for (int c = 1; c <= 18; c++) begin
      tick(c == 2);
      total++;
      if ({13'd0, a33, 13'd0, b33, ld33} !== {exp_a[0], exp_b[0], exp_l[0]}) begin
        bad++;
        $display("FAIL early33 E%0d got a=%b b=%b ld=%b exp a=%b b=%b ld=%b",
                 c, a33, b33, ld33, exp_a[0][2:0], exp_b[0][2:0], exp_l[0]);
      end
      total++;
      if ({14'd0, a23, 13'd0, b23, ld23} !== {exp_a[1], exp_b[1], exp_l[1]}) begin
        bad++;
        $display("FAIL early23 E%0d got a=%b b=%b ld=%b exp a=%b b=%b ld=%b",
                 c, a23, b23, ld23, exp_a[1][1:0], exp_b[1][2:0], exp_l[1]);
      end
      if (c == 6) begin
        total++;
        if (a33 !== 3'b110) begin
          bad++;
          $display("FAIL early_E6_en got %b exp 110", a33);
        end
      end
    end
  endtask

  task automatic test_finished_held();
    reset_cycle();
    for (int c = 1; c <= 18; c++) begin
      tick(1'b1);
      total++;
      if ({13'd0, a33, 13'd0, b33, ld33} !== {exp_a[0], exp_b[0], exp_l[0]}) begin
        bad++;
        $display("FAIL held33 E%0d got a=%b b=%b ld=%b exp a=%b b=%b ld=%b",
                 c, a33, b33, ld33, exp_a[0][2:0], exp_b[0][2:0], exp_l[0]);
      end
      total++;
      if ({14'd0, a23, 13'd0, b23, ld23} !== {exp_a[1], exp_b[1], exp_l[1]}) begin
        bad++;
        $display("FAIL held23 E%0d got a=%b b=%b ld=%b exp a=%b b=%b ld=%b",
                 c, a23, b23, ld23, exp_a[1][1:0], exp_b[1][2:0], exp_l[1]);
      end
    end
  endtask

  task automatic test_drain_reset();
    reset_cycle();
    for (int c = 1; c <= 12; c++) tick(c == 6);
    total++;
    if (ld33 !== 1'b0 || a33 !== 3'b000) begin
      bad++;
      $display("FAIL drain_pre got a=%b ld=%b exp a=000 ld=0", a33, ld33);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({a33, b33, ld33, a23, b23, ld23} !== 13'd0) begin
      bad++;
      $display("FAIL drain_async got %b exp 0", {a33, b33, ld33, a23, b23, ld23});
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int c = 1; c <= 6; c++) begin
      tick(1'b0);
      total++;
      if ({13'd0, a33, 13'd0, b33, ld33} !== {exp_a[0], exp_b[0], exp_l[0]}) begin
        bad++;
        $display("FAIL drain_rerun33 E%0d got a=%b b=%b ld=%b exp a=%b b=%b ld=%b",
                 c, a33, b33, ld33, exp_a[0][2:0], exp_b[0][2:0], exp_l[0]);
      end
      total++;
      if ({14'd0, a23, 13'd0, b23, ld23} !== {exp_a[1], exp_b[1], exp_l[1]}) begin
        bad++;
        $display("FAIL drain_rerun23 E%0d got a=%b b=%b ld=%b exp a=%b b=%b ld=%b",
                 c, a23, b23, ld23, exp_a[1][1:0], exp_b[1][2:0], exp_l[1]);
      end
    end
  endtask

  task automatic test_random();
    int p;
    bit fin;
    for (int run = 0; run < 8; run++) begin
      reset_cycle();
      p = int'($urandom_range(0, 4));
      for (int c = 1; c <= 70; c++) begin
        fin = ($urandom_range(0, 9) < p);
        tick(fin);
        total++;
        if ({13'd0, a33, 13'd0, b33, ld33} !== {exp_a[0], exp_b[0], exp_l[0]}) begin
          bad++;
          $display("FAIL rand33 run%0d E%0d got a=%b b=%b ld=%b exp a=%b b=%b ld=%b",
                   run, c, a33, b33, ld33, exp_a[0][2:0], exp_b[0][2:0], exp_l[0]);
        end
        total++;
        if ({14'd0, a23, 13'd0, b23, ld23} !== {exp_a[1], exp_b[1], exp_l[1]}) begin
          bad++;
          $display("FAIL rand23 run%0d E%0d got a=%b b=%b ld=%b exp a=%b b=%b ld=%b",
                   run, c, a23, b23, ld23, exp_a[1][1:0], exp_b[1][2:0], exp_l[1]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_early_finish();
    test_finished_held();
    test_drain_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/test_control.md
TEST_CONTROL -- requirements
Module: test_control

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning the number of array rows (width of A_start_en), legal values 2..16.
REQ-002 The block SHALL have parameter M, default 3, meaning the number of array columns (width of B_start_en), legal values 2..16.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port finished, input, 1 bit: a level meaning the operand streams are exhausted.
REQ-006 The block SHALL have port A_start_en, output, N bits: per-row A feed enables, bit i gating row i.
REQ-007 The block SHALL have port B_start_en, output, M bits: per-column B feed enables, bit j gating column j.
REQ-008 The block SHALL have port load, output, 1 bit: a one-cycle pulse telling the MACs to latch or present their accumulated C.

Function
REQ-009 The block SHALL implement the states IDLE, SKEW_IN, STREAM, SKEW_OUT, DRAIN, LOAD and DONE, encoded in registered state with all outputs registered.
REQ-010 In IDLE, the block SHALL move to SKEW_IN on the first clock edge with rst high, with the enables still all zero.
REQ-011 In SKEW_IN, each edge SHALL shift a 1 into bit 0 of both enable vectors (en <= {en[W-2:0],1}), and a vector already all-ones SHALL stay all-ones.
REQ-012 SKEW_IN SHALL go to STREAM on the edge where both vectors become all-ones, which takes max(N,M) edges.
REQ-013 In STREAM, the enables SHALL hold all-ones, and the block SHALL go to SKEW_OUT on the edge after the finished flag is set.
REQ-014 The finished flag SHALL be sticky: it is set by finished=1 sampled in SKEW_IN or STREAM, it is ignored in all other states, and it is cleared on reset and on leaving LOAD.
REQ-015 In SKEW_OUT, each edge SHALL shift a 0 into bit 0 of both vectors, so row or column k drops k cycles after row or column 0.
REQ-016 SKEW_OUT SHALL go to DRAIN on the edge where both vectors become all-zero.
REQ-017 DRAIN SHALL last exactly N+M-1 cycles, covering the array flush plus the MAC register, counted by an internal counter of width $clog2(N+M)+1.
REQ-018 The block SHALL then enter LOAD for exactly one cycle, with load=1 only while in LOAD.
REQ-019 After LOAD, the block SHALL enter DONE, with all outputs 0, until reset.
REQ-020 A finished level held throughout SHALL shorten STREAM to one cycle but SHALL NOT skip SKEW_IN or SKEW_OUT.
REQ-021 When N≠M, the shorter vector SHALL saturate first and hold its value while the longer vector completes.

Reset
REQ-022 rst=0 SHALL force, asynchronously, state to IDLE, A_start_en=0, B_start_en=0, load=0, the drain counter to 0 and the finished flag to 0.
REQ-023 Reset asserted mid-operation in any state SHALL abort immediately to these values, and the sequence SHALL restart from IDLE after release.

Configuration
REQ-024 With TEST_CONTROL_RESTART_EN defined, LOAD SHALL return to SKEW_IN, with the enables at 0 and the flag cleared, for a new tile, and DONE SHALL be unreachable.
REQ-025 With TEST_CONTROL_RESTART_EN undefined, LOAD SHALL go to DONE and stay there until reset.

Verification (N=M=3, edge E1 = first edge after rst release)
REQ-026 Release rst with finished=0 -> E1: en=000, SKEW_IN; E2 en=001; E3 en=011; E4 en=111, STREAM; load stays 0.
REQ-027 finished=1 for one cycle sampled at E6 -> E7 SKEW_OUT; E8 en=110; E9 100; E10 000, DRAIN; E15 LOAD with load=1; E16 DONE with load=0.
REQ-028 finished=1 pulsed during SKEW_IN at E2 only -> the flag holds, STREAM lasts one cycle, and SKEW_OUT starts at E5.
REQ-029 rst asserted while in DRAIN -> all outputs read 0 immediately, with no edge needed; after release the E1..E4 pattern repeats.
REQ-030 N=2, M=3 -> after E2 A=01, B=001; after E3 A=11, B=011; after E4 A=11, B=111 with STREAM entered; the drain then lasts 4 cycles.
REQ-031 With TEST_CONTROL_RESTART_EN defined -> the edge after load=1 shows SKEW_IN, and en goes 001 one edge later.
